hex_scan_ctrl: RTL and testbench
================================

Name: hex_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode seven-segment digits that share one hex-to-segment decoder. It owns a double-buffered display value loaded over a valid/ready handshake and steps a digit index at a programmable refresh rate. For each digit it presents the selected nibble to the shared decoder, registers the returned segment pattern, and drives the matching active-low digit enable. Optional leading-zero blanking is included.

Parameters:
NDIG, 4, number of digits scanned; legal range 2..8; index width IW = clog2(NDIG)
PRESCALE, 50000, clock cycles each digit is lit; legal minimum 2

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
en  in  1  scan enable
lzb  in  1  leading-zero blanking enable
load_valid  in  1  load_data is valid
load_ready  out  1  controller can accept load_data
load_data  in  4*NDIG  display value; nibble k drives digit k, digit 0 is least significant
nib  out  4  nibble presented to the shared decoder's 4-bit input
seg_in  in  7  decoder output {a,b,c,d,e,f,g}, active-high, combinational from nib
seg_out  out  7  registered segment drive, active-high
dig_n  out  NDIG  registered one-hot-low digit enables
frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset (rst_n low at a rising clk edge) sets:
  - outputs: seg_out=0, dig_n=all 1s, frame_done=0, load_ready=1
  - internal state: idx=0, prescale count=0, shadow=0, pending flag=0
  - rst_n has no effect between clock edges.
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1.
  - tick is asserted in the cycle where count==PRESCALE-1; count wraps to 0 on the next edge.
- nib = shadow[4*idx +: 4]. It is combinational from registered idx and shadow; no other logic sits in that path.
- On a tick edge:
  - seg_out <= blank(idx) ? 7'b0000000 : seg_in
  - dig_n <= ~(1<<idx)
  - idx <= (idx==NDIG-1) ? 0 : idx+1
  - Each digit stays lit for exactly PRESCALE cycles.
  - After en rises, the first digit lights PRESCALE cycles later.
- Between ticks, seg_out and dig_n hold their values.
- Frame boundary is a tick with idx==NDIG-1. On that edge:
  - frame_done pulses high for one cycle.
  - If the pending flag was set before this edge, shadow <= pending value and the pending flag clears.
- Load handshake:
  - load_ready = ~pending flag.
  - A transfer occurs on an edge where load_valid && load_ready; it captures load_data into the pending register and sets the pending flag.
  - A transfer on the frame-boundary edge is not committed at that boundary; it commits at the next boundary.
  - While the flag is set, load_ready=0; load_valid has no effect and load_data is ignored.
  - The producer must hold load_valid and load_data stable until load_ready is 1.
- Leading-zero blanking:
  - blank(k) = lzb && (k != 0) && all shadow nibbles k..NDIG-1 are zero.
  - Digit 0 is never blanked.
  - The value 0 with lzb=1 shows a single "0".
- Disable:
  - en=0 at an edge: next edge gives dig_n=all 1s, seg_out=0, idx=0, count=0, frame_done=0.
  - While en=0, a pending value commits to shadow on the edge after its transfer, so load_ready stays 1 except for that one cycle.
  - Re-enabling restarts at digit 0.
- en falling mid-digit or mid-frame: scan aborts immediately with no partial frame_done.
- The decoder's segment codes are taken as-is; the controller never re-encodes them.

Test Plan:
All scenarios use NDIG=4, PRESCALE=4, and the team's hex decoder wired nib->in, out->seg_in.
1. Reset, en=1, load 0x1234 at cycle 2:
   - load_ready goes low at cycle 3.
   - Commit happens at the first frame boundary (edge 16); load_ready=1 and frame_done=1 one cycle after.
   - Next frame shows: dig_n=1110 with seg 0110011 ("4"), then dig_n=1101 "3" (1111001), then 1011 "2" (1101101), then 0111 "1" (0110000).
2. lzb=1, load 0x0040:
   - digits 3 and 2 show seg_out=0000000.
   - digit 1 shows 0110011; digit 0 shows 1111110.
   - With lzb=0, digits 3 and 2 show 1111110.
3. Back-to-back loads 0xAAAA then 0x5555 with load_valid held high:
   - second value is stalled (load_ready=0) until the boundary after 0xAAAA commits.
   - Displayed frames are 0xAAAA (1110111), then 0x5555 (1011011); no value is lost or skipped.
4. Load asserted exactly on a frame-boundary edge:
   - the old value is displayed for one more full frame.
   - the new value commits at the following boundary.
5. en dropped while idx=2:
   - next edge gives dig_n=1111, seg_out=0; no frame_done pulse.
   - en raised again: digit 0 lights 4 cycles later.
6. rst_n held low for one edge at idx=3 with a pending load:
   - all outputs return to reset values; pending value discarded; load_ready=1.
   - a rst_n low pulse between edges changes nothing.

Source files
------------

// File: rtl/hex_scan_ctrl.sv
// Scan controller for a bank of multiplexed common-anode seven-segment digits.
// Holds a double-buffered display value and feeds one shared hex decoder a digit at a time.
module hex_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              lzb,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] load_data,
  output logic [3:0]        nib,
  input  logic [6:0]        seg_in,
  output logic [6:0]        seg_out,
  output logic [NDIG-1:0]   dig_n,
  output logic              frame_done
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = $clog2(PRESCALE);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NDIG - 1);
  localparam logic [IW-1:0]   IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [NDIG-1:0] DIG_OFF  = {NDIG{1'b1}};
  localparam logic [NDIG-1:0] DIG_ONE  = {{(NDIG-1){1'b0}}, 1'b1};

  logic [CW-1:0]     cnt_r;
  logic [IW-1:0]     idx_r;
  logic [4*NDIG-1:0] shadow_r;
  logic [4*NDIG-1:0] pend_val_r;
  logic              pend_r;
  logic [6:0]        seg_r;
  logic [NDIG-1:0]   dig_n_r;
  logic              frame_done_r;

  logic              tick_s;
  logic              boundary_s;
  logic              take_s;
  logic              commit_s;
  logic              blank_s;
  logic [NDIG-1:0]   zero_from_s;

  assign tick_s     = en && (cnt_r == CNT_MAX);
  assign boundary_s = tick_s && (idx_r == LAST_IDX);
  assign take_s     = load_valid && !pend_r;
  // With the scan stopped there is no frame boundary to wait for, so commit at once.
  assign commit_s   = pend_r && (boundary_s || !en);

  assign nib        = shadow_r[{idx_r, 2'b00} +: 4];
  assign load_ready = ~pend_r;
  assign seg_out    = seg_r;
  assign dig_n      = dig_n_r;
  assign frame_done = frame_done_r;

  // zero_from_s[k]: every shadow nibble from k up to the most significant is zero
  always_comb begin
    logic acc;
    zero_from_s = {NDIG{1'b0}};
    acc         = 1'b1;
    for (int k = NDIG - 1; k >= 0; k--) begin
      acc            = acc && (shadow_r[4*k +: 4] == 4'h0);
      zero_from_s[k] = acc;
    end
  end

  // Blank the current digit when it is a leading zero (digit 0 always shows)
  always_comb begin
    if (lzb && (idx_r != IDX_ZERO)) begin
      blank_s = zero_from_s[idx_r];
    end else begin
      blank_s = 1'b0;
    end
  end

  // Prescaler, digit index and registered segment/digit drive
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r        <= CNT_ZERO;
      idx_r        <= IDX_ZERO;
      seg_r        <= 7'b0000000;
      dig_n_r      <= DIG_OFF;
      frame_done_r <= 1'b0;
    end else if (!en) begin
      cnt_r        <= CNT_ZERO;
      idx_r        <= IDX_ZERO;
      seg_r        <= 7'b0000000;
      dig_n_r      <= DIG_OFF;
      frame_done_r <= 1'b0;
    end else begin
      cnt_r        <= tick_s ? CNT_ZERO : (cnt_r + CNT_ONE);
      frame_done_r <= boundary_s;
      if (tick_s) begin
        seg_r   <= blank_s ? 7'b0000000 : seg_in;
        dig_n_r <= ~(DIG_ONE << idx_r);
        idx_r   <= (idx_r == LAST_IDX) ? IDX_ZERO : (idx_r + IDX_ONE);
      end
    end
  end

  // Load handshake into the pending buffer and commit into the shadow value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_r   <= {(4*NDIG){1'b0}};
      pend_val_r <= {(4*NDIG){1'b0}};
      pend_r     <= 1'b0;
    end else if (commit_s) begin
      shadow_r <= pend_val_r;
      pend_r   <= 1'b0;
    end else if (take_s) begin
      pend_val_r <= load_data;
      pend_r     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Randomised scoreboard bench for hex_scan_ctrl (NDIG=4, PRESCALE=4) with a hex decoder model.
module tb_hex_scan_ctrl;
  localparam int NDIG = 4;
  localparam int P    = 4;

  typedef struct {
    int         cyc;
    logic [3:0] dig;
    logic [6:0] seg;
    logic       fd;
    logic       rdy;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        lzb = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0000;
  logic        load_ready;
  logic [3:0]  nib;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic [3:0]  dig_n;
  logic        frame_done;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  ev_t q[$];

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1111110;  4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;  4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;  4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;  4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;  4'h9: hex7 = 7'b1111011;
      4'hA: hex7 = 7'b1110111;  4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110;  4'hD: hex7 = 7'b0111101;
      4'hE: hex7 = 7'b1001111;  4'hF: hex7 = 7'b1000111;
      default: hex7 = 7'b0000000;
    endcase
  endfunction

  function automatic logic blank(input logic lz, input int k, input logic [15:0] v);
    return lz && (k != 0) && ((v >> (4 * k)) == 16'h0000);
  endfunction

  function automatic logic [15:0] rand_val();
    logic [15:0] v;
    v = 16'($urandom);
    for (int k = 0; k < NDIG; k++)
      if ($urandom_range(0, 1) == 0) v[4*k +: 4] = 4'h0;
    return v;
  endfunction

  assign seg_in = hex7(nib);

  hex_scan_ctrl #(.NDIG(NDIG), .PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .lzb(lzb),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .nib(nib), .seg_in(seg_in), .seg_out(seg_out), .dig_n(dig_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference: the n-th enabled edge is a tick when n is a multiple of P; tick m lights digit m mod NDIG.
  initial begin : model
    int          n;
    int          d;
    logic [15:0] sh;
    logic [15:0] pv;
    logic        pp;
    logic        bnd;
    logic        take;
    logic [3:0]  ed;
    logic [6:0]  es;
    logic        efd;
    logic        erdy;
    logic        have;
    logic [12:0] prev;
    ev_t         e;
    n = 0; sh = 16'h0; pv = 16'h0; pp = 1'b0; have = 1'b0; prev = 13'h0;
    ed = 4'hF; es = 7'h0; efd = 1'b0; erdy = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        n = 0; sh = 16'h0; pv = 16'h0; pp = 1'b0;
        ed = 4'hF; es = 7'h0; efd = 1'b0; erdy = 1'b1;
      end else begin
        bnd  = 1'b0;
        efd  = 1'b0;
        take = load_valid && !pp;
        if (en) begin
          n++;
          if (n % P == 0) begin
            d   = (n / P - 1) % NDIG;
            es  = blank(lzb, d, sh) ? 7'b0000000 : hex7(sh[4*d +: 4]);
            ed  = ~(4'b0001 << d);
            bnd = (d == NDIG - 1);
            efd = bnd;
          end
        end else begin
          n = 0; ed = 4'hF; es = 7'h0;
        end
        if (pp && (bnd || !en)) begin
          sh = pv; pp = 1'b0;
        end else if (take) begin
          pv = load_data; pp = 1'b1;
        end
        erdy = !pp;
      end
      if (!have || ({ed, es, efd, erdy} != prev)) begin
        e.cyc = cyc; e.dig = ed; e.seg = es; e.fd = efd; e.rdy = erdy;
        q.push_back(e);
        prev = {ed, es, efd, erdy};
        have = 1'b1;
      end
    end
  end

  // Monitor: every change of the DUT's outputs is one presented event
  initial begin : monitor
    logic        have;
    logic [12:0] prev;
    logic [12:0] cur;
    ev_t         e;
    have = 1'b0; prev = 13'h0;
    forever begin
      @(negedge clk);
      cur = {dig_n, seg_out, frame_done, load_ready};
      if (!have || (cur !== prev)) begin
        have = 1'b1;
        prev = cur;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d actual dig_n=%b seg=%b fd=%b rdy=%b required no change",
                   cyc, dig_n, seg_out, frame_done, load_ready);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.dig !== dig_n || e.seg !== seg_out || e.fd !== frame_done || e.rdy !== load_ready) begin
            failures++;
            $display("FAIL output_event actual cyc=%0d dig_n=%b seg=%b fd=%b rdy=%b required cyc=%0d dig_n=%b seg=%b fd=%b rdy=%b",
                     cyc, dig_n, seg_out, frame_done, load_ready, e.cyc, e.dig, e.seg, e.fd, e.rdy);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_dig(input logic [3:0] v);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (dig_n !== v && k < 300);
    if (dig_n !== v) begin
      checks++;
      failures++;
      $display("FAIL wait_dig_timeout actual=%b required=%b", dig_n, v);
    end
  endtask

  task automatic wait_fd();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_done !== 1'b1 && k < 300);
    if (frame_done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL wait_frame_done_timeout actual=%b required=1", frame_done);
    end
  endtask

  // Present a value and hold it until accepted; load_valid is left high for the caller
  task automatic load(input logic [15:0] v);
    int k;
    load_valid = 1'b1;
    load_data  = v;
    k = 0;
    while (load_ready !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("ready_low_after_transfer", {31'h0, load_ready}, 32'h0);
  endtask

  task automatic expect_seg(input string nm, input logic [3:0] d, input logic [6:0] s);
    wait_dig(d);
    chk(nm, {25'h0, seg_out}, {25'h0, s});
  endtask

  initial begin : stim
    logic rdy_q;
    logic rst_q;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    chk("reset_dig_n", {28'h0, dig_n}, 32'hF);
    chk("reset_ready", {31'h0, load_ready}, 32'h1);

    // Basic load and digit order
    load(16'h1234);
    load_valid = 1'b0;
    wait_fd();
    expect_seg("d0_4", 4'b1110, 7'b0110011);
    expect_seg("d1_3", 4'b1101, 7'b1111001);
    expect_seg("d2_2", 4'b1011, 7'b1101101);
    expect_seg("d3_1", 4'b0111, 7'b0110000);

    // Leading-zero blanking on and off
    lzb = 1'b1;
    load(16'h0040);
    load_valid = 1'b0;
    wait_fd();
    expect_seg("lzb_d0", 4'b1110, 7'b1111110);
    expect_seg("lzb_d1", 4'b1101, 7'b0110011);
    expect_seg("lzb_d2", 4'b1011, 7'b0000000);
    expect_seg("lzb_d3", 4'b0111, 7'b0000000);
    lzb = 1'b0;
    expect_seg("nolzb_d0", 4'b1110, 7'b1111110);
    expect_seg("nolzb_d2", 4'b1011, 7'b1111110);
    expect_seg("nolzb_d3", 4'b0111, 7'b1111110);

    // Back-to-back loads with load_valid held high
    load(16'hAAAA);
    load(16'h5555);
    load_valid = 1'b0;
    repeat (60) @(negedge clk);

    // Load landing exactly on a frame-boundary edge
    wait_dig(4'b1011);
    repeat (P - 1) @(negedge clk);
    load(16'h9876);
    load_valid = 1'b0;
    repeat (50) @(negedge clk);

    // Disable while idx==2, then re-enable
    wait_dig(4'b1101);
    en = 1'b0;
    @(negedge clk);
    chk("disable_dig_n", {28'h0, dig_n}, 32'hF);
    chk("disable_seg", {25'h0, seg_out}, 32'h0);
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (30) @(negedge clk);

    // Reset with a pending load at idx==3, then a between-edge reset glitch
    wait_dig(4'b1011);
    load(16'hFEDC);
    load_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", {31'h0, load_ready}, 32'h1);
    chk("rst_dig_n", {28'h0, dig_n}, 32'hF);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // Randomised traffic
    rdy_q = load_ready;
    rst_q = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (load_valid && rdy_q && rst_q) load_valid = 1'b0;
      if (!load_valid && $urandom_range(0, 9) < 3) begin
        load_valid = 1'b1;
        load_data  = rand_val();
      end
      if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      else if (en && $urandom_range(0, 149) == 0) en = 1'b0;
      if ($urandom_range(0, 31) == 0) lzb = !lzb;
      rst_n = ($urandom_range(0, 399) != 0);
      rdy_q = load_ready;
      rst_q = rst_n;
    end
    @(negedge clk);
    load_valid = 1'b0;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
